mux_rr_arbiter: RTL and testbench

- Shares one registered N:1 data multiplexer between N requesters using round-robin arbitration with burst locking.
- Each requester presents a valid/ready stream with a last-beat marker.
- The arbiter grants one requester, steers its beats through the mux into a one-entry output register, and holds the grant until the last beat is accepted.
- Sits between multiple producers and a single shared downstream consumer.

---
 rtl/mux_rr_arbiter_if.sv | 27 ++
 rtl/mux_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
`timescale 1ns/1ps
// mux_rr_arbiter_if: requester-side and consumer-side handshake bundle for
// the shared round-robin mux. The "slave" modport is the arbiter view; the
// "master" modport is the environment (producers plus downstream consumer).
interface mux_rr_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_ready;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
`timescale 1ns/1ps
// mux_rr_arbiter: N requesters share one registered N:1 data mux.
// A round-robin search picks a winner while idle; the grant then stays locked
// on that requester until the beat flagged "last" is accepted. Beats pass
// through a one-entry output register with valid/ready flow control.
module mux_rr_arbiter #(
    parameter int N   = 4,
    parameter int DW  = 8,
    parameter int IDW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_rr_arbiter_if.slave bus,
    output logic [IDW-1:0]  grant_id,
    output logic            busy
);

    // Reject parameter sets where the grant index cannot address every requester.
    if (IDW != $clog2(N)) begin : g_idw_check
        $error("mux_rr_arbiter: IDW must equal clog2(N)");
    end
    if (N < 2 || N > 8) begin : g_n_check
        $error("mux_rr_arbiter: N must be in 2..8");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state, state_next;
    logic [IDW-1:0] ptr, ptr_next;
    logic [IDW-1:0] grant_next;

    logic [IDW-1:0] winner;
    logic           winner_found;
    logic [IDW:0]   cand;

    logic           grant_ready;
    logic           xfer;
    logic           grant_last;
    logic [DW-1:0]  grant_data;
    logic [N-1:0]   req_ready_c;

    logic           out_valid_r;
    logic [DW-1:0]  out_data_r;
    logic           out_last_r;

    // Round-robin search: first valid requester starting just after ptr, with
    // wrap. cand is one bit wider than the index so ptr+i cannot overflow
    // before the modulo-N fold.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        cand         = '0;
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(N)) begin
                cand = cand - (IDW+1)'(N);
            end
            if (!winner_found && bus.req_valid[cand[IDW-1:0]]) begin
                winner_found = 1'b1;
                winner       = cand[IDW-1:0];
            end
        end
    end

    // Steer the granted requester's beat and generate its ready; the output
    // register can take a beat when empty or when it drains this cycle.
    always_comb begin
        req_ready_c = '0;
        grant_ready = (state == GRANT) && (!out_valid_r || bus.out_ready);
        grant_data  = bus.req_data[int'(grant_id)*DW +: DW];
        grant_last  = bus.req_last[grant_id];
        if (grant_ready) begin
            req_ready_c[grant_id] = 1'b1;
        end
        xfer = grant_ready && bus.req_valid[grant_id];
    end

    // Next-state logic: arbitrate from IDLE (a mandatory one-cycle bubble),
    // release the grant only when the last beat of the burst is accepted.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        grant_next = grant_id;
        case (state)
            IDLE: begin
                if (winner_found) begin
                    grant_next = winner;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (xfer && grant_last) begin
                    state_next = IDLE;
                    ptr_next   = grant_id;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, fairness pointer and grant index; ptr resets to N-1 so that
    // requester 0 is first in line after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= IDW'(N-1);
            grant_id <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            grant_id <= grant_next;
        end
    end

    // One-entry output register: load on transfer, clear when drained,
    // otherwise hold data and last stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
        end else if (xfer) begin
            out_valid_r <= 1'b1;
            out_data_r  <= grant_data;
            out_last_r  <= grant_last;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign busy          = (state == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
`timescale 1ns/1ps
// tb_mux_rr_arbiter: requester queues feed the arbiter, a scoreboard queue
// holds the expected output beats in order, and hand sequences cover
// backpressure, valid gaps and asynchronous reset mid-burst.
module tb_mux_rr_arbiter;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int IDW = 2;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic [IDW-1:0] grant_id;
    logic           busy;

    mux_rr_arbiter_if #(.N(N), .DW(DW)) bus();

    mux_rr_arbiter #(.N(N), .DW(DW), .IDW(IDW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         grp;
        int         src;
        logic [7:0] data;
        logic       last;
        logic [7:0] exp_data;
        logic       exp_last;
    } vec_t;

    vec_t         tbl[$];
    logic [8:0]   rq[N][$];
    logic [8:0]   exp_q[$];
    int           stamp_q[$];
    logic [N-1:0] gap = '0;
    logic [N-1:0] acc = '0;
    int           cycle_cnt = 0;
    int           vec_count = 0;
    int           miscompares = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic add_vec(input int grp, input int src, input logic [7:0] d, input logic l,
                           input logic [7:0] ed, input logic el);
        vec_t v;
        v.grp = grp; v.src = src; v.data = d; v.last = l; v.exp_data = ed; v.exp_last = el;
        tbl.push_back(v);
    endtask

    task automatic applyStimulus(input int grp);
        foreach (tbl[k]) begin
            if (tbl[k].grp == grp) begin
                rq[tbl[k].src].push_back({tbl[k].last, tbl[k].data});
                exp_q.push_back({tbl[k].exp_last, tbl[k].exp_data});
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst out_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst out_last", 32'(bus.out_last), 32'd0);
        checkOutput("rst req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst grant_id", 32'(grant_id), 32'd0);
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_q.delete();
        stamp_q.delete();
        gap = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checkOutput({name, " beats left"}, 32'(exp_q.size()), 32'd0);
        repeat (2) step();
    endtask

    // Requester driver and output monitor, all at the falling edge.
    initial begin
        logic [8:0] e;
        logic [8:0] f;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    vec_count++;
                    miscompares++;
                    $display("[TB] FAIL unexpected beat: got 0x%0h, want none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("beat data", 32'(bus.out_data), 32'(e[7:0]));
                    checkOutput("beat last", 32'(bus.out_last), 32'(e[8]));
                    stamp_q.push_back(cycle_cnt);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() > 0 && !gap[i]) begin
                    f = rq[i][0];
                    bus.req_valid[i]         = 1'b1;
                    bus.req_data[i*DW +: DW] = f[7:0];
                    bus.req_last[i]          = f[8];
                end else begin
                    bus.req_valid[i]         = 1'b0;
                    bus.req_data[i*DW +: DW] = '0;
                    bus.req_last[i]          = 1'b0;
                end
            end
            #1;
            for (int i = 0; i < N; i++) begin
                if (rst_n && bus.req_valid[i] && bus.req_ready[i]) acc[i] = 1'b1;
            end
        end
    end

    // Retire accepted beats just after the edge that consumed them.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    if (rq[i].size() > 0) void'(rq[i].pop_front());
                    acc[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        bus.out_ready = 1'b1;

        add_vec(1, 0, 8'hA5, 1'b1, 8'hA5, 1'b1);
        add_vec(2, 0, 8'h00, 1'b1, 8'h00, 1'b1);
        add_vec(2, 1, 8'h11, 1'b1, 8'h11, 1'b1);
        add_vec(2, 2, 8'h22, 1'b1, 8'h22, 1'b1);
        add_vec(2, 3, 8'h33, 1'b1, 8'h33, 1'b1);
        add_vec(2, 0, 8'h00, 1'b1, 8'h00, 1'b1);
        add_vec(3, 0, 8'h01, 1'b0, 8'h01, 1'b0);
        add_vec(3, 0, 8'h02, 1'b0, 8'h02, 1'b0);
        add_vec(3, 0, 8'h03, 1'b1, 8'h03, 1'b1);
        add_vec(3, 1, 8'h10, 1'b1, 8'h10, 1'b1);
        add_vec(4, 2, 8'h21, 1'b0, 8'h21, 1'b0);
        add_vec(4, 2, 8'h22, 1'b0, 8'h22, 1'b0);
        add_vec(4, 2, 8'h23, 1'b0, 8'h23, 1'b0);
        add_vec(4, 2, 8'h24, 1'b1, 8'h24, 1'b1);
        add_vec(5, 3, 8'h31, 1'b0, 8'h31, 1'b0);
        add_vec(5, 3, 8'h32, 1'b0, 8'h32, 1'b0);
        add_vec(5, 3, 8'h33, 1'b1, 8'h33, 1'b1);
        add_vec(50, 0, 8'h0A, 1'b1, 8'h0A, 1'b1);
        add_vec(6, 0, 8'h40, 1'b1, 8'h40, 1'b1);
        add_vec(6, 1, 8'h41, 1'b0, 8'h41, 1'b0);
        add_vec(6, 1, 8'h42, 1'b0, 8'h42, 1'b0);
        add_vec(6, 1, 8'h43, 1'b1, 8'h43, 1'b1);
        add_vec(60, 0, 8'h50, 1'b1, 8'h50, 1'b1);
        add_vec(60, 1, 8'h51, 1'b1, 8'h51, 1'b1);

        #2;
        $display("[TB] test 1: reset and single requester");
        do_reset();
        applyStimulus(1);
        step();
        checkOutput("t1 busy after arb", 32'(busy), 32'd1);
        checkOutput("t1 grant_id", 32'(grant_id), 32'd0);
        step();
        checkOutput("t1 out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("t1 out_data", 32'(bus.out_data), 32'hA5);
        checkOutput("t1 out_last", 32'(bus.out_last), 32'd1);
        step();
        checkOutput("t1 busy idle", 32'(busy), 32'd0);
        wait_drain("t1", 20);

        $display("[TB] test 2: round-robin order");
        do_reset();
        applyStimulus(2);
        wait_drain("t2", 60);
        checkOutput("t2 beat count", 32'(stamp_q.size()), 32'd5);
        for (int k = 1; k < 5; k++) begin
            if (k < stamp_q.size()) checkOutput("t2 spacing", 32'(stamp_q[k] - stamp_q[k-1]), 32'd2);
        end

        $display("[TB] test 3: burst lock");
        do_reset();
        applyStimulus(3);
        wait_drain("t3", 60);
        checkOutput("t3 beat count", 32'(stamp_q.size()), 32'd4);
        if (stamp_q.size() == 4) begin
            checkOutput("t3 spacing b1", 32'(stamp_q[1] - stamp_q[0]), 32'd1);
            checkOutput("t3 spacing b2", 32'(stamp_q[2] - stamp_q[1]), 32'd1);
            checkOutput("t3 spacing req1", 32'(stamp_q[3] - stamp_q[2]), 32'd2);
        end

        $display("[TB] test 4: backpressure");
        do_reset();
        applyStimulus(4);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        checkOutput("t4 first beat seen", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            checkOutput("t4 hold valid", 32'(bus.out_valid), 32'd1);
            checkOutput("t4 hold data", 32'(bus.out_data), 32'h21);
            checkOutput("t4 hold ready2", 32'(bus.req_ready[2]), 32'd0);
        end
        bus.out_ready = 1'b1;
        wait_drain("t4", 40);

        $display("[TB] test 5: valid gap mid-burst");
        do_reset();
        applyStimulus(5);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        checkOutput("t5 first beat seen", 32'(bus.out_valid), 32'd1);
        gap[3] = 1'b1;
        applyStimulus(50);
        for (int k = 0; k < 2; k++) begin
            step();
            checkOutput("t5 gap grant_id", 32'(grant_id), 32'd3);
            checkOutput("t5 gap busy", 32'(busy), 32'd1);
            checkOutput("t5 gap ready0", 32'(bus.req_ready[0]), 32'd0);
        end
        gap[3] = 1'b0;
        wait_drain("t5", 40);

        $display("[TB] test 6: async reset mid-burst");
        do_reset();
        applyStimulus(6);
        n = 0;
        while (!(bus.out_valid && grant_id == 2'd1) && n < 30) begin
            step();
            n++;
        end
        checkOutput("t6 req1 beat held", 32'(bus.out_valid && grant_id == 2'd1), 32'd1);
        #2;
        do_reset();
        applyStimulus(60);
        n = 0;
        while (!busy && n < 20) begin
            step();
            n++;
        end
        checkOutput("t6 post-reset busy", 32'(busy), 32'd1);
        checkOutput("t6 post-reset grant", 32'(grant_id), 32'd0);
        wait_drain("t6", 40);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule
